// File: rtl/imul_iterative_var.sv
// imul_iterative_var
//   Iterative shift-and-add integer multiplier with variable latency.
//   Produces the full 2*NBITS-bit product of two NBITS-bit operands, in
//   unsigned or signed (two's complement) mode, chosen per transaction.
//   Iteration stops as soon as the remaining multiplier bits are all zero.
//   Signed operands are multiplied as magnitudes; the product is negated
//   in one extra cycle when the operand signs differ.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous, active-low reset
//   istream_val  request valid
//   istream_rdy  request ready (high only while idle)
//   istream_msg  {mode, a[NBITS-1:0], b[NBITS-1:0]}; mode=1 means signed
//   ostream_val  response valid (high only while holding a result)
//   ostream_rdy  response ready
//   ostream_msg  2*NBITS-bit product
module imul_iterative_var #(
    parameter int unsigned NBITS = 32,
    parameter int unsigned CW    = $clog2(NBITS) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               istream_val,
    output logic               istream_rdy,
    input  logic [2*NBITS:0]   istream_msg,
    output logic               ostream_val,
    input  logic               ostream_rdy,
    output logic [2*NBITS-1:0] ostream_msg
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN,
        DONE
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);

    state_t             state_q;
    logic [2*NBITS-1:0] a_q;
    logic [NBITS-1:0]   b_q;
    logic [2*NBITS-1:0] prod_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q;
    logic               rdy_q;
    logic               val_q;

    // Operand decode and per-iteration datapath values
    logic               mode_d;
    logic [NBITS-1:0]   a_in_d;
    logic [NBITS-1:0]   b_in_d;
    logic [NBITS-1:0]   a_mag_d;
    logic [NBITS-1:0]   b_mag_d;
    logic               neg_d;
    logic               last_d;
    logic [2*NBITS-1:0] prod_add_d;

    always_comb begin
        mode_d  = istream_msg[2*NBITS];
        a_in_d  = istream_msg[2*NBITS-1:NBITS];
        b_in_d  = istream_msg[NBITS-1:0];
        // Magnitude of the most negative value wraps to 2^(NBITS-1), which
        // is exactly the correct unsigned magnitude in NBITS bits.
        a_mag_d = (mode_d && a_in_d[NBITS-1]) ? (~a_in_d + NBITS'(1)) : a_in_d;
        b_mag_d = (mode_d && b_in_d[NBITS-1]) ? (~b_in_d + NBITS'(1)) : b_in_d;
        neg_d   = mode_d && (a_in_d[NBITS-1] ^ b_in_d[NBITS-1]);
        // Last iteration when no set multiplier bits remain above bit 0.
        last_d  = (b_q[NBITS-1:1] == '0) || (cnt_q == CNT_LAST);
        prod_add_d = b_q[0] ? (prod_q + a_q) : prod_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rdy_q   <= 1'b1;
            val_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (istream_val && rdy_q) begin
                        a_q     <= {{NBITS{1'b0}}, a_mag_d};
                        b_q     <= b_mag_d;
                        neg_q   <= neg_d;
                        prod_q  <= '0;
                        cnt_q   <= '0;
                        rdy_q   <= 1'b0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    prod_q <= prod_add_d;
                    a_q    <= a_q << 1;
                    b_q    <= b_q >> 1;
                    cnt_q  <= cnt_q + CW'(1);
                    if (last_d) begin
                        if (neg_q) begin
                            state_q <= SIGN;
                        end else begin
                            state_q <= DONE;
                            val_q   <= 1'b1;
                        end
                    end
                end
                SIGN: begin
                    prod_q  <= ~prod_q + (2*NBITS)'(1);
                    state_q <= DONE;
                    val_q   <= 1'b1;
                end
                DONE: begin
                    if (ostream_rdy) begin
                        state_q <= IDLE;
                        val_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    val_q   <= 1'b0;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign istream_rdy = rdy_q;
    assign ostream_val = val_q;
    assign ostream_msg = prod_q;

endmodule

// File: tb/tb_imul_iterative_var.sv
// Testbench for imul_iterative_var (NBITS=32): directed products and
// latencies, back-pressure, asynchronous reset mid-multiply, and a random
// stream checked against an arithmetic reference model.
module tb_imul_iterative_var;

    localparam int unsigned NB = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          istream_val;
    logic          istream_rdy;
    logic [2*NB:0] istream_msg;
    logic          ostream_val;
    logic          ostream_rdy;
    logic [2*NB-1:0] ostream_msg;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    imul_iterative_var #(.NBITS(NB)) dut (
        .clk        (clk),
        .reset      (reset),
        .istream_val(istream_val),
        .istream_rdy(istream_rdy),
        .istream_msg(istream_msg),
        .ostream_val(ostream_val),
        .ostream_rdy(ostream_rdy),
        .ostream_msg(ostream_msg)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference product: plain 64-bit integer arithmetic.
    function automatic logic [63:0] ref_prod(input bit m, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (m) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Reference latency: highest set bit of |b| (at least one iteration),
    // plus one cycle when signs differ in signed mode.
    function automatic int ref_lat(input bit m, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] bm;
        int n;
        bm = (m && b[31]) ? (~b + 32'd1) : b;
        n = 1;
        for (int i = 0; i < 32; i++) if (bm[i]) n = i + 1;
        return n + ((m && (a[31] ^ b[31])) ? 1 : 0);
    endfunction

    // Waits for istream_rdy (bounded) then presents one request.
    // Returns #1 after the acceptance edge.
    task automatic put_req(input bit m, input logic [31:0] a, input logic [31:0] b);
        int k;
        k = 0;
        while (istream_rdy !== 1'b1 && k < 100) begin
            @(posedge clk); #1; k++;
        end
        istream_msg = {m, a, b};
        istream_val = 1'b1;
        @(posedge clk); #1;
        istream_val = 1'b0;
        istream_msg = {$urandom_range(0, 1) == 1, $urandom, $urandom};
    endtask

    // Bounded wait for ostream_val; lat counts edges after acceptance.
    task automatic wait_val(output int lat);
        lat = 0;
        while (ostream_val !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic directed(input string tag, input bit m, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        int lat;
        ostream_rdy = 1'b1;
        put_req(m, a, b);
        wait_val(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_prod"}, ostream_msg, exp);
        @(posedge clk); #1;
        check({tag, "_rdy_back"}, 64'(istream_rdy), 64'd1);
        check({tag, "_val_drop"}, 64'(ostream_val), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit          m;
        logic [31:0] a, b;
        logic [63:0] hold, mcap, exp;
        bit          v, got, stale;
        int          lat, k, gap, seen_lat;

        reset       = 1'b1;
        istream_val = 1'b0;
        istream_msg = '0;
        ostream_rdy = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("reset_irdy", 64'(istream_rdy), 64'd1);
        check("reset_oval", 64'(ostream_val), 64'd0);
        check("reset_omsg", ostream_msg, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        directed("u3x5",      1'b0, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 3);
        directed("s-3x5",     1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 4);
        directed("u_bzero",   1'b0, 32'h1234_5678, 32'h0000_0000, 64'h0, 1);
        directed("s_negzero", 1'b1, 32'h8000_0000, 32'h0000_0000, 64'h0, 2);
        directed("u_max",     1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32);
        directed("s_minmin",  1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 32);
        directed("s_minx1",   1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 2);

        // Back-pressure: 7 * -9 = -63, held for 5 cycles in DONE
        ostream_rdy = 1'b0;
        put_req(1'b1, 32'h0000_0007, 32'hFFFF_FFF7);
        wait_val(lat);
        check("bp_lat", 64'(lat), 64'd5);
        check("bp_prod", ostream_msg, 64'hFFFF_FFFF_FFFF_FFC1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_msg", ostream_msg, 64'hFFFF_FFFF_FFFF_FFC1);
            check("bp_hold_irdy", 64'(istream_rdy), 64'd0);
        end
        ostream_rdy = 1'b1;
        @(posedge clk); #1;
        check("bp_irdy_after", 64'(istream_rdy), 64'd1);
        check("bp_oval_after", 64'(ostream_val), 64'd0);

        // Random stream with random request gaps and random sink readiness
        for (int t = 0; t < 100; t++) begin
            m = ($urandom_range(0, 1) == 1);
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (m && $urandom_range(0, 1) == 1) b = ~b + 32'd1;
            if ($urandom_range(0, 9) == 0) b = 32'd0;
            exp = ref_prod(m, a, b);
            gap = $urandom_range(0, 3);
            repeat (gap) begin @(posedge clk); #1; end
            ostream_rdy = 1'b0;
            put_req(m, a, b);
            got = 1'b0;
            k = 0;
            seen_lat = -1;
            mcap = '0;
            while (!got && k < 400) begin
                ostream_rdy = ($urandom_range(0, 1) == 1);
                v = ostream_val;
                mcap = ostream_msg;
                if (v && seen_lat < 0) seen_lat = k;
                @(posedge clk); #1; k++;
                if (v && ostream_rdy) got = 1'b1;
            end
            check("rand_prod", got ? mcap : 64'hDEAD_DEAD_DEAD_DEAD, exp);
            check("rand_lat", 64'(seen_lat), 64'(ref_lat(m, a, b)));
        end
        ostream_rdy = 1'b1;

        // Asynchronous reset during iteration 10 of a 32-iteration multiply
        put_req(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        check("arst_irdy", 64'(istream_rdy), 64'd1);
        check("arst_oval", 64'(ostream_val), 64'd0);
        check("arst_omsg", ostream_msg, 64'd0);
        @(negedge clk) reset = 1'b1;
        stale = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ostream_val === 1'b1) stale = 1'b1;
        end
        check("arst_no_stale", 64'(stale), 64'd0);
        directed("post_rst", 1'b0, 32'h0000_1234, 32'h0000_0100, 64'h0000_0000_0012_3400, 9);

        hold = 64'(tests);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imul_iterative_var.md
Name: imul_iterative_var

Overview:
- Parametrised, iterative, variable-latency integer multiplier; successor to the single-cycle lab1 multiplier.
- Supports operand width NBITS, a full 2*NBITS-bit product, and per-transaction signed/unsigned mode.
- Ends early once the remaining multiplier bits are zero.
- Sits behind the same val/rdy stream interfaces, so the lab1 test harness sources and sinks drop in unchanged.

Parameters:
- NBITS, 32, operand width in bits; legal range 2..64.
- CW, $clog2(NBITS)+1, iteration counter width; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on the posedge.
- reset  input  1  asynchronous, active-low reset.
- istream_val  input  1  request valid.
- istream_rdy  output  1  request ready.
- istream_msg  input  2*NBITS+1  {mode, a[NBITS-1:0], b[NBITS-1:0]}, with mode at the MSB; mode=1 is signed two's complement.
- ostream_val  output  1  response valid.
- ostream_rdy  input  1  response ready.
- ostream_msg  output  2*NBITS  full product.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; istream_rdy=1; ostream_val=0; ostream_msg=0.
  - Internal registers a_reg, b_reg, prod, cnt and neg are all cleared.
  - Reset while busy drops the in-flight transaction; no response is ever produced for it.
- FSM states: IDLE, CALC, SIGN, DONE.
  - istream_rdy=1 only in IDLE.
  - ostream_val=1 only in DONE.
  - Both are registered/decoded from state, with no combinational path from the inputs.
- IDLE:
  - On istream_val&&istream_rdy, capture the operands and go to CALC.
  - If mode=1: a_reg=|a| and b_reg=|b|, both as NBITS-bit unsigned magnitudes (|-2^(NBITS-1)| = 2^(NBITS-1)), and neg = a[MSB]^b[MSB].
  - If mode=0: a_reg=a, b_reg=b, neg=0.
  - prod=0, cnt=0.
  - a_reg is held in a 2*NBITS-bit register, zero-extended.
- CALC, one iteration per cycle:
  - If b_reg[0], prod += a_reg (mod 2^(2*NBITS)).
  - a_reg <<= 1; b_reg >>= 1; cnt++.
  - Exit when (b_reg>>1)==0 or cnt==NBITS-1. The next state is SIGN if neg, else DONE.
  - Iteration count n = max(1, msb_index(b_reg)+1); n=1 for b=0 or b=1, and n=NBITS maximum.
- SIGN: one cycle; prod = -prod (2*NBITS-bit two's complement), then go to DONE. Taken whenever neg=1, including a zero product; -0 = 0.
- DONE:
  - ostream_msg=prod is held stable while ostream_val=1 and ostream_rdy=0.
  - On ostream_rdy=1, go to IDLE.
  - The next request cannot be accepted in the same cycle; it is accepted the following cycle at the earliest.
- Timing: request accepted at edge E0 -> ostream_val=1 after edge E0+n+s, where s=1 if neg else 0.
  - Minimum request-to-request interval is n+s+2 cycles.
- istream_msg is ignored outside IDLE. ostream_rdy is ignored outside DONE.
- No X propagation: every register has a defined reset value and a defined next value in every state.
- Line trace: istream val/rdy/msg, then state as I/C/S/D, then ostream val/rdy/msg, all through vc_trace.

Test Plan (NBITS=32, sink always ready unless noted):
- Unsigned 3*5: msg={0,0x3,0x5} -> 0x000000000000000F; n=3, so ostream_val rises 3 cycles after acceptance.
- Signed -3*5: msg={1,0xFFFFFFFD,0x5} -> 0xFFFFFFFFFFFFFFF1 via SIGN; valid 4 cycles after acceptance.
- Zero and early exit:
  - {0,0x12345678,0x0} -> 0, valid after 1 cycle.
  - {1,0x80000000,0x0} -> 0 with the SIGN cycle taken (neg=1), valid after 2 cycles.
- Extremes:
  - Unsigned 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE00000001, n=32.
  - Signed 0x80000000*0x80000000 -> 0x4000000000000000.
  - Signed 0x80000000*0x00000001 -> 0xFFFFFFFF80000000.
- Back-pressure: hold ostream_rdy=0 for 5 cycles in DONE.
  - ostream_msg must stay constant and istream_rdy must stay 0.
  - After ostream_rdy rises, istream_rdy=1 on the next cycle.
  - A 100-transaction random stream with random val/rdy gaps, both modes, must match a reference model.
- Reset mid-CALC: assert reset low asynchronously during iteration 10 of a 32-iteration multiply.
  - istream_rdy=1 and ostream_val=0 immediately, without waiting for a clock edge.
  - After release, the first new transaction returns its correct product and no stale response appears.
